// File: rtl/ram_io_responder_if.sv
// Byte-wide CPU memory bus plus the UART receive/transmit byte streams that
// meet at ram_io_responder. The master side is the CPU together with the UART.
interface ram_io_responder_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        rdy_out;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output cpu_a, cpu_wdata, cpu_wr, rx_valid, rx_data, tx_ready,
        input  cpu_rdata, rdy_out, rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  cpu_a, cpu_wdata, cpu_wr, rx_valid, rx_data, tx_ready,
        output cpu_rdata, rdy_out, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/ram_io_responder.sv
// Memory-bus responder: 128 KB RAM, UART RX/TX byte FIFOs, cycle-counter snapshot and stop flag at 0x30000.
// Optional RAM_BOUNDS_CHECK_EN flags accesses to 0x20000-0x2FFFF and adds the sticky bounds_err_o port.
module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_LOG2   = 4,
    parameter int RX_FIFO_LOG2   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    ram_io_responder_if.slave bus,
`ifdef RAM_BOUNDS_CHECK_EN
    output logic              bounds_err_o,
`endif
    output logic              stop_o
);
    localparam int TX_DEPTH = 1 << TX_FIFO_LOG2;
    localparam int RX_DEPTH = 1 << RX_FIFO_LOG2;

    typedef logic [TX_FIFO_LOG2:0] tx_cnt_t;
    typedef logic [RX_FIFO_LOG2:0] rx_cnt_t;

    logic [7:0] ram_mem [2**RAM_ADDR_WIDTH];
    logic [7:0] tx_mem  [TX_DEPTH];
    logic [7:0] rx_mem  [RX_DEPTH];

    logic [TX_FIFO_LOG2-1:0] tx_wp_q, tx_rp_q;
    tx_cnt_t                 tx_cnt_q, tx_cnt_d;
    logic [RX_FIFO_LOG2-1:0] rx_wp_q, rx_rp_q;
    rx_cnt_t                 rx_cnt_q, rx_cnt_d;
    logic [31:0]             cyc_q, snap_q, snap_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    stop_q, stop_d, rdy_q, rdy_d;

    logic       tx_push, tx_pop, rx_push, rx_pop, rx_ready_w, ram_we;
    logic [7:0] tx_push_data;

    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [15:0]               io_off;
    logic                      is_io, is_data, is_timer;
    logic                      unused_addr_hi;

    assign ram_idx        = bus.cpu_a[RAM_ADDR_WIDTH-1:0];
    assign io_off         = bus.cpu_a[15:0];
    assign is_io          = bus.cpu_a[17:16] == 2'b11;
    assign is_data        = is_io && (io_off == 16'h0000);
    assign is_timer       = is_io && (io_off[15:2] == 14'h0001);
    assign unused_addr_hi = ^bus.cpu_a[31:18];

`ifdef RAM_BOUNDS_CHECK_EN
    logic is_oob, oob_hit, bounds_err_q;
    assign is_oob = bus.cpu_a[17:16] == 2'b10;
`endif

    assign tx_pop     = (tx_cnt_q != '0) && bus.tx_ready;
    assign rx_ready_w = rx_cnt_q != rx_cnt_t'(RX_DEPTH);
    assign rx_push    = bus.rx_valid && rx_ready_w;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        rdata_d      = rdata_q;
        snap_d       = snap_q;
        stop_d       = stop_q;
        tx_push      = 1'b0;
        tx_push_data = 8'h00;
        rx_pop       = 1'b0;
        ram_we       = 1'b0;
`ifdef RAM_BOUNDS_CHECK_EN
        oob_hit      = 1'b0;
`endif
        if (rdy_q) begin
            if (bus.cpu_wr) begin
                if (is_data) begin
                    tx_push      = bus.cpu_wdata != 8'h00;
                    tx_push_data = bus.cpu_wdata;
                end else if (is_timer && io_off[1:0] == 2'd0) begin
                    tx_push = 1'b1;
                    stop_d  = 1'b1;
                end else if (!is_io) begin
`ifdef RAM_BOUNDS_CHECK_EN
                    oob_hit = is_oob;
                    ram_we  = !is_oob;
`else
                    ram_we  = 1'b1;
`endif
                end
            end else begin
                if (is_data) begin
                    rx_pop  = rx_cnt_q != '0;
                    rdata_d = rx_pop ? rx_mem[rx_rp_q] : 8'h00;
                end else if (is_timer) begin
                    // Only byte 0 reloads the snapshot, so a 4-byte read sequence is coherent.
                    if (io_off[1:0] == 2'd0) begin
                        snap_d  = cyc_q;
                        rdata_d = cyc_q[7:0];
                    end else begin
                        rdata_d = snap_q[{io_off[1:0], 3'b000} +: 8];
                    end
                end else if (is_io) begin
                    rdata_d = 8'h00;
                end else begin
`ifdef RAM_BOUNDS_CHECK_EN
                    oob_hit = is_oob;
                    rdata_d = is_oob ? 8'hEE : ram_mem[ram_idx];
`else
                    rdata_d = ram_mem[ram_idx];
`endif
                end
            end
        end

        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + tx_cnt_t'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - tx_cnt_t'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + rx_cnt_t'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - rx_cnt_t'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // Built from next-state count so one slot is still free for the access accepted this cycle.
        rdy_d = !stop_d && (tx_cnt_d < tx_cnt_t'(TX_DEPTH - 1));
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cyc_q    <= 32'd0;
            snap_q   <= 32'd0;
            rdata_q  <= 8'h00;
            stop_q   <= 1'b0;
            rdy_q    <= 1'b1;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            cyc_q    <= cyc_q + 32'd1;
            snap_q   <= snap_d;
            rdata_q  <= rdata_d;
            stop_q   <= stop_d;
            rdy_q    <= rdy_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (tx_push) tx_wp_q <= tx_wp_q + TX_FIFO_LOG2'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + TX_FIFO_LOG2'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + RX_FIFO_LOG2'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + RX_FIFO_LOG2'(1);
        end
    end

    // NOTE: storage arrays carry no reset; validity comes from the reset pointers and counts.
    always_ff @(posedge clk_in) begin
        if (ram_we)  ram_mem[ram_idx] <= bus.cpu_wdata;
        if (tx_push) tx_mem[tx_wp_q]  <= tx_push_data;
        if (rx_push) rx_mem[rx_wp_q]  <= bus.rx_data;
    end

`ifdef RAM_BOUNDS_CHECK_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)       bounds_err_q <= 1'b0;
        else if (oob_hit) bounds_err_q <= 1'b1;
    end
    assign bounds_err_o = bounds_err_q;
`endif

    assign bus.cpu_rdata = rdata_q;
    assign bus.rdy_out   = rdy_q;
    assign bus.rx_ready  = rx_ready_w;
    assign bus.tx_valid  = tx_cnt_q != '0;
    assign bus.tx_data   = tx_mem[tx_rp_q];
    assign stop_o        = stop_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: expected read bytes and TX bytes are queued
// when stimulus is driven and compared when the responder delivers them.
module tb_ram_io_responder;
    localparam logic [31:0] IDLE_A = 32'h0000_0010;

    logic clk_in = 1'b0;
    logic rst_in;
    logic stop_o;
`ifdef RAM_BOUNDS_CHECK_EN
    logic bounds_err_o;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          tx_seen  = 0;
    logic [7:0]  rd_exp_q [$];
    string       rd_tag_q [$];
    logic [7:0]  tx_exp_q [$];
    bit          chk_rd = 1'b0;
    bit          rd_due = 1'b0;
    logic [31:0] m_cyc;
    logic [31:0] snap;

    ram_io_responder_if bus ();

    ram_io_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus),
`ifdef RAM_BOUNDS_CHECK_EN
        .bounds_err_o (bounds_err_o),
`endif
        .stop_o       (stop_o)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle count: cleared by reset, +1 on every clock out of reset.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) m_cyc <= 32'd0;
        else        m_cyc <= m_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                rd_due = 1'b0;
            end else begin
                if (rd_due) begin
                    if (rd_exp_q.size() == 0)
                        check("rd_no_expect", 32'(rd_exp_q.size()), 32'd1);
                    else
                        check(rd_tag_q.pop_front(), 32'(bus.cpu_rdata), 32'(rd_exp_q.pop_front()));
                end
                rd_due = chk_rd && bus.rdy_out && !bus.cpu_wr;
                if (bus.tx_valid && bus.tx_ready) begin
                    tx_seen++;
                    if (tx_exp_q.size() == 0)
                        check("tx_extra_byte", 32'(tx_exp_q.size()), 32'd1);
                    else
                        check("tx_data", 32'(bus.tx_data), 32'(tx_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk_in);
        #2;
    endtask

    task automatic set_idle();
        bus.cpu_a     = IDLE_A;
        bus.cpu_wdata = 8'h00;
        bus.cpu_wr    = 1'b0;
        chk_rd        = 1'b0;
    endtask

    task automatic access(input logic wr, input logic [31:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input string tag);
        bit ok;
        ok            = 1'b0;
        bus.cpu_a     = a;
        bus.cpu_wdata = d;
        bus.cpu_wr    = wr;
        if (!wr) begin
            chk_rd = 1'b1;
            rd_exp_q.push_back(exp);
            rd_tag_q.push_back(tag);
        end else if (a == 32'h0003_0000 && d != 8'h00) begin
            tx_exp_q.push_back(d);
        end else if (a == 32'h0003_0004) begin
            tx_exp_q.push_back(8'h00);
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_in);
            ok = bus.rdy_out;
        end
        if (!ok) check({tag, "_accept_timeout"}, 32'(ok), 32'd1);
        cycle();
        set_idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        access(1'b1, a, d, 8'h00, "wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
        access(1'b0, a, 8'h00, exp, tag);
    endtask

    task automatic rx_send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cycle();
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        set_idle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        rst_in       = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("rst_rdata",    32'(bus.cpu_rdata), 32'h00);
        check("rst_rdy",      32'(bus.rdy_out),   32'd1);
        check("rst_tx_valid", 32'(bus.tx_valid),  32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready),  32'd1);
        check("rst_stop",     32'(stop_o),        32'd0);
        cycle();

        // RAM write then read-back with one-cycle latency, including the top byte.
        wr(32'h0000_0010, 8'hA5);
        rd(32'h0000_0010, 8'hA5, "ram_10");
        wr(32'h0001_FFFF, 8'h3C);
        rd(32'h0001_FFFF, 8'h3C, "ram_1ffff");

        // TX stream: the zero byte is dropped.
        wr(32'h0003_0000, 8'h41);
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0000, 8'h42);
        repeat (4) cycle();
        check("tx_seq_drained", 32'(tx_exp_q.size()), 32'd0);
        check("tx_seq_count",   32'(tx_seen),         32'd2);
        check("tx_seq_stop",    32'(stop_o),          32'd0);

        // Unmapped IO offsets.
        rd(32'h0003_0008, 8'h00, "io_other_read");
        wr(32'h0003_0008, 8'h99);

        // TX back-pressure: rdy_out drops after the 15th accepted byte.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            wr(32'h0003_0000, 8'h50 + 8'(i));
            if (i == 13) check("rdy_before_full", 32'(bus.rdy_out), 32'd1);
        end
        check("rdy_after_15",  32'(bus.rdy_out),  32'd0);
        check("tx_valid_full", 32'(bus.tx_valid), 32'd1);
        fork
            wr(32'h0003_0000, 8'h5F);
            begin
                repeat (4) cycle();
                check("rdy_stalled", 32'(bus.rdy_out), 32'd0);
                bus.tx_ready = 1'b1;
            end
        join
        repeat (20) cycle();
        check("tx_fill_drained", 32'(tx_exp_q.size()), 32'd0);
        check("tx_fill_count",   32'(tx_seen),         32'd18);

        // RX stream, then a read racing a push into the empty FIFO.
        rx_send(8'h31);
        rx_send(8'h32);
        rd(32'h0003_0000, 8'h31, "rx_first");
        rd(32'h0003_0000, 8'h32, "rx_second");
        rd(32'h0003_0000, 8'h00, "rx_empty");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        rd(32'h0003_0000, 8'h00, "rx_race_empty");
        bus.rx_valid = 1'b0;
        rd(32'h0003_0000, 8'h77, "rx_race_byte");

        // RX full: the 17th byte is refused.
        for (int i = 0; i < 16; i++) rx_send(8'h60 + 8'(i));
        check("rx_full_ready", 32'(bus.rx_ready), 32'd0);
        rx_send(8'hFF);
        for (int i = 0; i < 16; i++) rd(32'h0003_0000, 8'h60 + 8'(i), "rx_full_drain");
        rd(32'h0003_0000, 8'h00, "rx_after_drain");
        check("rx_ready_again", 32'(bus.rx_ready), 32'd1);

`ifdef RAM_BOUNDS_CHECK_EN
        check("bounds_err_init", 32'(bounds_err_o), 32'd0);
        rd(32'h0002_0004, 8'hEE, "oob_read");
        check("bounds_err_set", 32'(bounds_err_o), 32'd1);
`else
        wr(32'h0002_0004, 8'h77);
        rd(32'h0000_0004, 8'h77, "oob_alias");
`endif

        // Counter snapshot taken at 0x3FE; later bytes must come from it, not the live counter.
        while (m_cyc < 32'd1022) cycle();
        snap = m_cyc;
        rd(32'h0003_0004, snap[7:0], "cnt_byte0");
        cycle();
        cycle();
        rd(32'h0003_0005, snap[15:8],  "cnt_byte1");
        rd(32'h0003_0006, snap[23:16], "cnt_byte2");
        rd(32'h0003_0007, snap[31:24], "cnt_byte3");

        // Stop: terminator byte emitted, CPU held, read data held.
        rd(IDLE_A, 8'hA5, "pre_stop_read");
        wr(32'h0003_0004, 8'h00);
        check("stop_set",       32'(stop_o),      32'd1);
        check("rdy_after_stop", 32'(bus.rdy_out), 32'd0);
        repeat (4) cycle();
        check("stop_tx_drained", 32'(tx_exp_q.size()), 32'd0);
        check("stop_sticky",     32'(stop_o),          32'd1);
        check("rdata_hold",      32'(bus.cpu_rdata),   32'hA5);

        // Asynchronous reset: outputs return to reset values before any clock edge.
        rst_in = 1'b1;
        #1;
        check("arst_rdata",    32'(bus.cpu_rdata), 32'h00);
        check("arst_stop",     32'(stop_o),        32'd0);
        check("arst_tx_valid", 32'(bus.tx_valid),  32'd0);
        check("arst_rx_ready", 32'(bus.rx_ready),  32'd1);
        check("arst_rdy",      32'(bus.rdy_out),   32'd1);
        cycle();
        cycle();
        rst_in = 1'b0;
        cycle();
        check("post_rst_rdy",  32'(bus.rdy_out), 32'd1);
        check("post_rst_stop", 32'(stop_o),      32'd0);
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
